// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU core with request/acknowledge instruction and data ports.
// One instruction moves through FETCH, DECODE, optional MEM_RD, EXEC and optional MEM_WR.
module hack_cpu_mc #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_rd_req,
    output logic              dmem_wr_req,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              retired,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_EXEC,
        S_MEM_WR,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic [ADDR_W-1:0] r_daddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_retired;
    logic              r_halted;
    logic              r_halt_pend;

    logic              w_is_c;
    logic [DATA_W-1:0] w_x0, w_x1, w_y_src, w_y0, w_y1, w_f, w_alu;
    logic              w_zr, w_ng, w_jump, w_self;
    logic [ADDR_W-1:0] w_target, w_pc_inc;

    // Hack ALU: x is always D, y is A or the M value fetched in MEM_RD.
    assign w_is_c   = r_ir[DATA_W-1];
    assign w_x0     = r_ir[11] ? '0 : r_d;
    assign w_x1     = r_ir[10] ? ~w_x0 : w_x0;
    assign w_y_src  = r_ir[12] ? r_mdr : r_a;
    assign w_y0     = r_ir[9] ? '0 : w_y_src;
    assign w_y1     = r_ir[8] ? ~w_y0 : w_y0;
    assign w_f      = r_ir[7] ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign w_alu    = r_ir[6] ? ~w_f : w_f;
    assign w_zr     = (w_alu == '0);
    assign w_ng     = w_alu[DATA_W-1];
    assign w_jump   = w_is_c & (|(r_ir[2:0] & {w_ng, w_zr, ~(w_ng | w_zr)}));
    assign w_target = r_a[ADDR_W-1:0];
    assign w_self   = w_jump && (w_target == r_pc);
    assign w_pc_inc = r_pc + ADDR_W'(1);

    assign imem_req    = (r_state == S_FETCH) & ~reset;
    assign imem_addr   = r_pc;
    assign dmem_rd_req = (r_state == S_MEM_RD) & ~reset;
    assign dmem_wr_req = (r_state == S_MEM_WR) & ~reset;
    assign dmem_addr   = r_daddr;
    assign dmem_wdata  = r_wdata;
    assign retired     = r_retired;
    assign halted      = r_halted;
    assign pc          = r_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= L_RESET_PC;
            r_a         <= '0;
            r_d         <= '0;
            r_ir        <= '0;
            r_mdr       <= '0;
            r_daddr     <= '0;
            r_wdata     <= '0;
            r_retired   <= 1'b0;
            r_halted    <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_retired <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Captured before EXEC so both M read and M write use the pre-instruction A.
                    r_daddr <= r_a[ADDR_W-1:0];
                    r_state <= (w_is_c && r_ir[12]) ? S_MEM_RD : S_EXEC;
                end
                S_MEM_RD: begin
                    if (dmem_ack) begin
                        r_mdr   <= dmem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!w_is_c) begin
                        r_a       <= {1'b0, r_ir[DATA_W-2:0]};
                        r_pc      <= w_pc_inc;
                        r_retired <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        if (r_ir[5]) r_a <= w_alu;
                        if (r_ir[4]) r_d <= w_alu;
                        r_wdata <= w_alu;
                        if (!w_self) r_pc <= w_jump ? w_target : w_pc_inc;
                        // A halting instruction with dest M still completes its write first.
                        if (r_ir[3]) begin
                            r_halt_pend <= w_self;
                            r_state     <= S_MEM_WR;
                        end else begin
                            r_retired <= 1'b1;
                            if (w_self) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                S_MEM_WR: begin
                    if (dmem_ack) begin
                        r_retired <= 1'b1;
                        if (r_halt_pend) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: wait-stated ROM/RAM responders plus an instruction-level Hack model
// that predicts every fetch address, data access, PC after retirement and retire-to-retire latency.
module tb_hack_cpu_mc;

    localparam int DW    = 16;
    localparam int AW    = 15;
    localparam int MEMSZ = 32768;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          imem_ack   = 1'b0;
    logic [DW-1:0] imem_data  = '0;
    logic          dmem_ack   = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          imem_req, dmem_rd_req, dmem_wr_req, retired, halted;
    logic [AW-1:0] imem_addr, dmem_addr, pc;
    logic [DW-1:0] dmem_wdata;

    hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .dmem_rd_req(dmem_rd_req),
        .dmem_wr_req(dmem_wr_req),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .retired    (retired),
        .halted     (halted),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memories: imem is the ROM, dev_ram is what the core sees, m_ram is the model's view.
    logic [DW-1:0] imem    [0:MEMSZ-1];
    logic [DW-1:0] dev_ram [0:MEMSZ-1];
    logic [DW-1:0] m_ram   [0:MEMSZ-1];

    // Instruction-level model state and the expectations for the instruction in flight.
    logic [AW-1:0] m_pc = '0;
    logic [DW-1:0] m_a  = '0;
    logic [DW-1:0] m_d  = '0;
    bit            pend = 0, e_rd = 0, e_wr = 0, e_halt = 0;
    logic [AW-1:0] e_rd_addr, e_wr_addr, e_pc;
    logic [DW-1:0] e_wr_data, e_ir;
    int            e_lat, e_nacc;

    int n_ret = 0, n_rd = 0, n_wr = 0;
    int cyc = 0, last_ret = 0;
    bit have_prev = 0;
    int iw_fixed = 0, dw_fixed = 0;

    logic [5:0] comp_tab [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                  6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                  6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                  6'b000111, 6'b000000, 6'b010101};

    function automatic logic [DW-1:0] hack_comp(input logic [5:0] c, input logic [DW-1:0] x,
                                                input logic [DW-1:0] y);
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'h0000 - x;
            6'b110011: return 16'h0000 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'h0000;
        endcase
    endfunction

    function automatic logic [DW-1:0] c_ins(input logic a, input logic [5:0] comp,
                                            input logic [2:0] dest, input logic [2:0] jmp);
        return {3'b111, a, comp, dest, jmp};
    endfunction

    function automatic logic [DW-1:0] rand_instr();
        logic [DW-1:0] v;
        if ($urandom_range(0, 99) < 40) begin
            if ($urandom_range(0, 1) == 0) v = 16'($urandom_range(0, 31));
            else                            v = {1'b0, 15'($urandom)};
        end else begin
            v = c_ins(1'($urandom), comp_tab[$urandom_range(0, 17)], 3'($urandom),
                      ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7)));
        end
        return v;
    endfunction

    task automatic model_step(input logic [DW-1:0] ir);
        logic [DW-1:0]        y, out, old_a;
        logic signed [DW-1:0] s;
        bit                   taken;
        old_a  = m_a;
        e_ir   = ir;
        e_rd   = 0;
        e_wr   = 0;
        e_halt = 0;
        e_nacc = 0;
        if (!ir[15]) begin
            m_a   = {1'b0, ir[14:0]};
            m_pc  = m_pc + 15'd1;
            e_lat = 3;
        end else begin
            y   = ir[12] ? m_ram[old_a[14:0]] : old_a;
            out = hack_comp(ir[11:6], m_d, y);
            s   = out;
            case (ir[2:0])
                3'd1:    taken = (s > 0);
                3'd2:    taken = (s == 0);
                3'd3:    taken = (s >= 0);
                3'd4:    taken = (s < 0);
                3'd5:    taken = (s != 0);
                3'd6:    taken = (s <= 0);
                3'd7:    taken = 1;
                default: taken = 0;
            endcase
            e_rd      = ir[12];
            e_rd_addr = old_a[14:0];
            e_wr      = ir[3];
            e_wr_addr = old_a[14:0];
            e_wr_data = out;
            e_nacc    = int'(ir[12]) + int'(ir[3]);
            e_lat     = 3 + e_nacc;
            if (ir[5]) m_a = out;
            if (ir[4]) m_d = out;
            if (taken && old_a[14:0] == m_pc) e_halt = 1;
            else if (taken)                   m_pc = old_a[14:0];
            else                              m_pc = m_pc + 15'd1;
        end
        e_pc = m_pc;
        pend = 1;
    endtask

    task automatic clear_model();
        m_pc = '0; m_a = '0; m_d = '0;
        pend = 0; e_rd = 0; e_wr = 0; e_halt = 0; have_prev = 0;
    endtask

    function automatic int pick_wait(input int f);
        return (f >= 0) ? f : int'($urandom_range(0, 3));
    endfunction

    // Memory responders and retire monitor, all evaluated mid-cycle on the falling edge.
    bit            i_busy = 0, d_busy = 0;
    int            i_cnt = 0, i_wait = 0, d_cnt = 0, d_wait = 0;
    logic [AW-1:0] i_addr0 = '0, d_addr0 = '0;
    logic [DW-1:0] d_wdata0 = '0;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (retired) begin
                check_val("retire_pending", 32'(pend), 1);
                check_val("retire_pc", 32'(pc), 32'(e_pc));
                check_val("retire_halted", 32'(halted), 32'(e_halt));
                check_val("retire_xfers_done", {e_rd, e_wr}, 0);
                if (have_prev && iw_fixed >= 0 && dw_fixed >= 0)
                    check_val("latency", 32'(cyc - last_ret), 32'(e_lat + iw_fixed + e_nacc * dw_fixed));
                $display("retire %0d: ir=%04h pc=%04h halted=%0d", n_ret, e_ir, pc, halted);
                pend      = 0;
                have_prev = 1;
                last_ret  = cyc;
                n_ret++;
            end
            if (imem_req && !reset) begin
                if (!i_busy) begin
                    i_busy  = 1;
                    i_cnt   = 0;
                    i_wait  = pick_wait(iw_fixed);
                    i_addr0 = imem_addr;
                end else begin
                    check_val("imem_addr_stable", 32'(imem_addr), 32'(i_addr0));
                end
                if (i_cnt >= i_wait) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[imem_addr];
                    check_val("fetch_pc", 32'(imem_addr), 32'(m_pc));
                    check_val("fetch_after_retire", 32'(pend), 0);
                    model_step(imem[m_pc]);
                    i_busy = 0;
                end else begin
                    imem_ack = 1'b0;
                    i_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                i_busy   = 0;
            end
            if ((dmem_rd_req || dmem_wr_req) && !reset) begin
                if (!d_busy) begin
                    check_val("rd_wr_exclusive", 32'(dmem_rd_req & dmem_wr_req), 0);
                    d_busy   = 1;
                    d_cnt    = 0;
                    d_wait   = pick_wait(dw_fixed);
                    d_addr0  = dmem_addr;
                    d_wdata0 = dmem_wdata;
                end else begin
                    check_val("dmem_addr_stable", 32'(dmem_addr), 32'(d_addr0));
                    if (dmem_wr_req) check_val("dmem_wdata_stable", 32'(dmem_wdata), 32'(d_wdata0));
                end
                if (d_cnt >= d_wait) begin
                    dmem_ack = 1'b1;
                    d_busy   = 0;
                    if (dmem_wr_req) begin
                        check_val("wr_expected", 32'(e_wr), 1);
                        check_val("wr_addr", 32'(dmem_addr), 32'(e_wr_addr));
                        check_val("wr_data", 32'(dmem_wdata), 32'(e_wr_data));
                        dev_ram[dmem_addr] = dmem_wdata;
                        if (e_wr) m_ram[e_wr_addr] = e_wr_data;
                        e_wr = 0;
                        n_wr++;
                    end else begin
                        check_val("rd_expected", 32'(e_rd), 1);
                        check_val("rd_addr", 32'(dmem_addr), 32'(e_rd_addr));
                        dmem_rdata = dev_ram[dmem_addr];
                        e_rd = 0;
                        n_rd++;
                    end
                end else begin
                    dmem_ack = 1'b0;
                    d_cnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                d_busy   = 0;
            end
        end
    end

    // Reset is only changed just after a rising edge, so the falling-edge responders see it stable.
    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clock);
        #1;
        check_val("reset_reqs", {imem_req, dmem_rd_req, dmem_wr_req}, 0);
        check_val("reset_retired", 32'(retired), 0);
        check_val("reset_halted", 32'(halted), 0);
        check_val("reset_pc", 32'(pc), 0);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int c = 0;
        while (!halted && n_ret < target && c < budget) begin
            @(negedge clock);
            c++;
        end
        @(negedge clock);
        check_val(tag, 32'(halted || n_ret >= target), 1);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < MEMSZ; i++) imem[i] = '0;
    endtask

    task automatic set_ram(input int addr, input logic [DW-1:0] val);
        dev_ram[addr] = val;
        m_ram[addr]   = val;
    endtask

    initial begin
        int            ret0, rd0, wr0, req_cycles;
        logic [DW-1:0] v;
        for (int i = 0; i < MEMSZ; i++) begin
            imem[i] = '0; dev_ram[i] = '0; m_ram[i] = '0;
        end

        // Store program: @0x1234; D=A; @5; M=D; then a halt loop at address 5.
        for (int pass = 0; pass < 2; pass++) begin
            iw_fixed = (pass == 0) ? 0 : 3;
            dw_fixed = 0;
            clear_imem();
            imem[0] = 16'h1234;
            imem[1] = c_ins(1'b0, 6'b110000, 3'b010, 3'b000);
            imem[2] = 16'd5;
            imem[3] = c_ins(1'b0, 6'b001100, 3'b001, 3'b000);
            imem[4] = 16'd5;
            imem[5] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
            set_ram(5, 16'h0000);
            ret0 = n_ret; rd0 = n_rd; wr0 = n_wr;
            do_reset();
            run_until(ret0 + 1000, 200, "store_prog_done");
            check_val("store_ram5", 32'(dev_ram[5]), 32'h1234);
            check_val("store_writes", 32'(n_wr - wr0), 1);
            check_val("store_reads", 32'(n_rd - rd0), 0);
            check_val("store_retires", 32'(n_ret - ret0), 6);
            check_val("store_halted", 32'(halted), 1);
        end
        iw_fixed = 0;

        // M read then a taken JLT: @7; D=M; @10; D;JLT -> pc 10, then halt at 11.
        clear_imem();
        imem[0]  = 16'd7;
        imem[1]  = c_ins(1'b1, 6'b110000, 3'b010, 3'b000);
        imem[2]  = 16'd10;
        imem[3]  = c_ins(1'b0, 6'b001100, 3'b000, 3'b100);
        imem[10] = 16'd11;
        imem[11] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        set_ram(7, 16'hFFFF);
        ret0 = n_ret; rd0 = n_rd;
        do_reset();
        run_until(ret0 + 1000, 200, "read_prog_done");
        check_val("read_count", 32'(n_rd - rd0), 1);
        check_val("read_retires", 32'(n_ret - ret0), 6);
        check_val("read_halt_pc", 32'(pc), 11);

        // Halt loop: @2; D=-1; 0;JMP at A=PC, then stay silent until reset.
        clear_imem();
        imem[0] = 16'd2;
        imem[1] = c_ins(1'b0, 6'b111010, 3'b010, 3'b000);
        imem[2] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        ret0 = n_ret;
        do_reset();
        run_until(ret0 + 1000, 100, "halt_prog_done");
        check_val("halt_flag", 32'(halted), 1);
        req_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (imem_req || dmem_rd_req || dmem_wr_req || retired) req_cycles++;
        end
        check_val("halt_quiet_cycles", 32'(req_cycles), 0);
        check_val("halt_pc_frozen", 32'(pc), 2);
        check_val("halt_sticky", 32'(halted), 1);
        do_reset();
        @(negedge clock);
        check_val("halt_cleared", 32'(halted), 0);

        // PC wrap: jump to 0x7FFF, execute an A-instr there, next fetch is at 0.
        clear_imem();
        imem[0]       = 16'h7FFF;
        imem[1]       = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        imem[MEMSZ-1] = 16'd3;
        ret0 = n_ret;
        do_reset();
        run_until(ret0 + 3, 100, "wrap_prog_done");
        check_val("pc_wrap", 32'(pc), 0);

        // Reset while a write is stalled: M=D+1 at A=0 must restart cleanly from pc 0 with A=D=0.
        clear_imem();
        imem[0] = c_ins(1'b0, 6'b011111, 3'b001, 3'b000);
        imem[1] = 16'd2;
        imem[2] = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        set_ram(0, 16'hBEEF);
        dw_fixed = 1000;
        do_reset();
        for (int i = 0; i < 30 && !dmem_wr_req; i++) @(negedge clock);
        check_val("stall_wr_req", 32'(dmem_wr_req), 1);
        repeat (3) @(negedge clock);
        dw_fixed = 0;
        wr0 = n_wr;
        ret0 = n_ret;
        do_reset();
        @(negedge clock);
        check_val("post_reset_imem_req", 32'(imem_req), 1);
        check_val("post_reset_imem_addr", 32'(imem_addr), 0);
        run_until(ret0 + 1000, 100, "restart_prog_done");
        check_val("restart_ram0", 32'(dev_ram[0]), 1);
        check_val("restart_writes", 32'(n_wr - wr0), 1);

        // Random programs under zero, fixed and random wait states.
        for (int r = 0; r < 4; r++) begin
            case (r)
                0:       begin iw_fixed = 0;  dw_fixed = 0;  end
                2:       begin iw_fixed = 2;  dw_fixed = 1;  end
                default: begin iw_fixed = -1; dw_fixed = -1; end
            endcase
            for (int i = 0; i < MEMSZ; i++) begin
                imem[i] = rand_instr();
                v = 16'($urandom);
                dev_ram[i] = v;
                m_ram[i]   = v;
            end
            ret0 = n_ret;
            do_reset();
            run_until(ret0 + 120, 120 * 30, "rand_run_done");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
